imm_gen_pipe: RTL
=================

// Module: imm_gen_pipe
// PURPOSE
//  Parametrised, registered immediate generator for the RV32I/RV64I front end.
//  Decodes the instruction format from the opcode and produces the extended immediate and the PC-relative target.
//  Sits between fetch and execute and decouples them with a valid/ready handshake and a 2-entry buffer.
//  Replaces the per-format parallel outputs with one muxed immediate plus a format tag.
// PARAMETERS
//  XLEN      32  datapath width of pc, imm and target; legal values are 32 and 64
//  SIGN_EXT  1   1 = RISC-V sign extension from inst[31]; 0 = legacy zero extension
//  PC_INC    4   added to pc for formats that have no PC-relative target
// PORTS
//  clk          in   1     rising-edge clock
//  rst          in   1     synchronous reset, active high
//  in_valid     in   1     instruction/pc pair is valid
//  in_ready     out  1     block can accept a pair this cycle
//  instruction  in   32    raw instruction word
//  pc           in   XLEN  address of the instruction
//  out_valid    out  1     head entry is valid
//  out_ready    in   1     consumer takes the head entry this cycle
//  imm          out  XLEN  extended immediate
//  target       out  XLEN  pc+imm or pc+PC_INC (see BEHAVIOUR)
//  fmt          out  3     0 none, 1 I, 2 S, 3 B, 4 U, 5 J
//  illegal      out  1     opcode is not in the decode table
// BEHAVIOUR
//  Opcode to format decode:
//   - I: 0010011, 0000011, 1100111, 1110011
//   - S: 0100011
//   - B: 1100011
//   - U: 0110111 (LUI), 0010111 (AUIPC)
//   - J: 1101111
//   - any other opcode: fmt=0, imm=0, illegal=1, target=pc+PC_INC
//  Raw immediate fields:
//   - I: inst[31:20]
//   - S: {inst[31:25], inst[11:7]}
//   - B: {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}
//   - J: {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}
//   - U: {inst[31:12], 12'b0}
//  Extension:
//   - SIGN_EXT=1: replicate the field MSB up to XLEN.
//   - SIGN_EXT=0: zero-fill. U uses the same rule above bit 31 when XLEN=64.
//  target:
//   - B, J and AUIPC: pc+imm.
//   - All other formats: pc+PC_INC.
//   - Both sums are modulo 2^XLEN and wrap silently.
//  Buffer:
//   - 2-entry FIFO of fully computed results; occupancy count is 0..2.
//   - Decode is done before the write, so stored entries never change.
//   - in_ready = (count != 2), combinational from count only and not from out_ready.
//   - out_valid = (count != 0). Outputs always show the head entry.
//   - Push on in_valid&&in_ready. Pop on out_valid&&out_ready.
//   - Latency: a pair pushed in cycle N is at the outputs in cycle N+1.
//  Boundary cases:
//   - Push+pop together at count=1: count stays 1 and the new entry becomes head next cycle.
//   - Push+pop together at count=0 cannot occur (no pop while empty).
//   - Full (count=2): no push. A pop frees a slot; in_ready rises the next cycle.
//   - out_valid held with out_ready=0: head outputs stay stable; no drop, no reorder.
//  Reset (any cycle, including mid-stream):
//   - count=0, out_valid=0; in_ready=1 from the next cycle.
//   - imm=0, target=0, fmt=0, illegal=0.
//   - Buffered entries are discarded.
// TESTING
//  1. XLEN=32, SIGN_EXT=1: inst=0xFFF00093 (addi -1), pc=0x100 -> next cycle: imm=0xFFFFFFFF, fmt=1, target=0x104.
//  2. inst=0xFE000EE3 (beq -4), pc=0x100 -> imm=0xFFFFFFFC, fmt=3, target=0xFC.
//     Same inst with SIGN_EXT=0 -> imm=0x00001FFC, target=0x20FC.
//  3. inst=0x123450B7 (lui) -> imm=0x12345000, fmt=4, target=pc+4.
//     inst=0x0000007F -> illegal=1, fmt=0, imm=0.
//  4. Backpressure: out_ready=0 with 3 pushes offered -> in_ready low after 2 accepts, head stable.
//     Then out_ready=1 -> 2 results drain in order, and the 3rd is accepted on the cycle after the first pop.
//  5. Streaming: in_valid=out_ready=1 for 8 cycles -> 8 results, 1-cycle latency, count never exceeds 1.
//  6. Reset asserted with count=2 -> next cycle out_valid=0, in_ready=1, all outputs 0.
//     No pre-reset entry ever appears at the outputs.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// Purpose: RV32I/RV64I immediate generator that decodes the instruction format
//          from the opcode, extends the immediate and forms the PC-relative target.
// Latency/backpressure: results reach the outputs one cycle after the push; a
//          2-entry result buffer decouples fetch and execute (in_ready = not full).
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   in_valid/in_ready        producer handshake for the instruction/pc pair
//   instruction, pc          raw instruction word and its address
//   out_valid/out_ready      consumer handshake for the head result
//   imm, target, fmt, illegal  head result: immediate, branch/next target,
//                            format tag (0 none, 1 I, 2 S, 3 B, 4 U, 5 J),
//                            opcode-not-decoded flag
module imm_gen_pipe #(
  parameter int XLEN     = 32,
  parameter bit SIGN_EXT = 1'b1,
  parameter int PC_INC   = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instruction,
  input  logic [XLEN-1:0] pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] target,
  output logic [2:0]      fmt,
  output logic            illegal
);

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5
  } fmt_e;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] target;
    logic [2:0]      fmt;
    logic            illegal;
  } entry_t;

  // ---------------------------------------------------------------------------
  // Decode (purely combinational, done before the buffer write)
  // ---------------------------------------------------------------------------
  logic [6:0]      opcode;
  logic            ext_bit;
  fmt_e            dec_fmt;
  logic            dec_illegal;
  logic            dec_pc_rel;
  logic [XLEN-1:0] u_imm;
  logic [XLEN-1:0] dec_imm;
  logic [XLEN-1:0] dec_target;
  entry_t          dec_entry;

  assign opcode = instruction[6:0];

  // Every immediate field has inst[31] as its MSB, so one fill bit serves all
  // formats; zero-extension simply forces it low.
  assign ext_bit = SIGN_EXT ? instruction[31] : 1'b0;

  generate
    if (XLEN > 32) begin : g_u_wide
      assign u_imm = {{(XLEN-32){ext_bit}}, instruction[31:12], 12'b0};
    end else begin : g_u_narrow
      assign u_imm = {instruction[31:12], 12'b0};
    end
  endgenerate

  always_comb begin
    dec_fmt     = FMT_NONE;
    dec_illegal = 1'b0;
    dec_pc_rel  = 1'b0;
    unique case (opcode)
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: dec_fmt = FMT_I;
      7'b0100011: dec_fmt = FMT_S;
      7'b1100011: begin
        dec_fmt    = FMT_B;
        dec_pc_rel = 1'b1;
      end
      7'b0110111: dec_fmt = FMT_U;            // LUI
      7'b0010111: begin                       // AUIPC
        dec_fmt    = FMT_U;
        dec_pc_rel = 1'b1;
      end
      7'b1101111: begin
        dec_fmt    = FMT_J;
        dec_pc_rel = 1'b1;
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  always_comb begin
    dec_imm = '0;
    unique case (dec_fmt)
      FMT_I: dec_imm = {{(XLEN-12){ext_bit}}, instruction[31:20]};
      FMT_S: dec_imm = {{(XLEN-12){ext_bit}}, instruction[31:25], instruction[11:7]};
      FMT_B: dec_imm = {{(XLEN-13){ext_bit}}, instruction[31], instruction[7],
                        instruction[30:25], instruction[11:8], 1'b0};
      FMT_U: dec_imm = u_imm;
      FMT_J: dec_imm = {{(XLEN-21){ext_bit}}, instruction[31], instruction[19:12],
                        instruction[20], instruction[30:21], 1'b0};
      default: dec_imm = '0;
    endcase
  end

  // Sums wrap modulo 2^XLEN by construction of the XLEN-wide adder.
  assign dec_target = pc + (dec_pc_rel ? dec_imm : XLEN'(PC_INC));

  assign dec_entry.imm     = dec_imm;
  assign dec_entry.target  = dec_target;
  assign dec_entry.fmt     = dec_fmt;
  assign dec_entry.illegal = dec_illegal;

  // ---------------------------------------------------------------------------
  // 2-entry result buffer
  // ---------------------------------------------------------------------------
  entry_t     mem_q [2];
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic [1:0] count_q;
  logic [1:0] count_d;
  logic       push;
  logic       pop;
  entry_t     head;

  // in_ready depends on occupancy only, never on out_ready, so there is no
  // combinational path from the consumer back to the producer.
  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= dec_entry;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

  // Outputs always reflect the head slot; storage is cleared on reset so the
  // post-reset outputs read as zero.
  assign head    = mem_q[rd_ptr_q];
  assign imm     = head.imm;
  assign target  = head.target;
  assign fmt     = head.fmt;
  assign illegal = head.illegal;

endmodule
